// File: rtl/button_conditioner_if.sv
// button_conditioner_if: groups the sample tick, the raw switch inputs and the
// conditioned outputs between the board-side driver and the conditioner.
// Optional rise-pulse signals exist only when PULSE_OUT_EN is defined.
interface button_conditioner_if;
    logic tick;
    logic left_raw;
    logic right_raw;
    logic left;
    logic right;
`ifdef PULSE_OUT_EN
    logic left_rise;
    logic right_rise;

    // Board side: drives the tick and the raw switches, observes the clean levels.
    modport master (
        output tick, left_raw, right_raw,
        input  left, right, left_rise, right_rise
    );

    // Conditioner side.
    modport slave (
        input  tick, left_raw, right_raw,
        output left, right, left_rise, right_rise
    );
`else
    // Board side: drives the tick and the raw switches, observes the clean levels.
    modport master (
        output tick, left_raw, right_raw,
        input  left, right
    );

    // Conditioner side.
    modport slave (
        input  tick, left_raw, right_raw,
        output left, right
    );
`endif
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces the raw left/right switches
// ahead of the tail-light FSM. Each channel has a 2-flop synchroniser feeding
// a 4-state debounce FSM that counts clk_div ticks while a new level is held.
// Optional feature macro: PULSE_OUT_EN adds registered one-clk rise pulses.
// STABLE_TICKS must lie in 1 .. 2**CNT_W-1 so the counter never wraps.
module button_conditioner #(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 3
) (
    input logic           clk,
    input logic           rst,
    button_conditioner_if.slave bus
);

    // Encoding chosen so state[1] is the debounced level, taken straight from a flop.
    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b11,
        S_FALL = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);

    logic [1:0] raw;
    logic [1:0] level;
    logic [1:0] rise;

    assign raw = {bus.right_raw, bus.left_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [1:0]       sync;
        logic             x_s;
        state_t           state;
        state_t           state_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;

        // Two-flop synchroniser; the raw pin reaches nothing but sync[0].
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync <= '0;
            end else begin
                sync <= {sync[0], raw[ch]};
            end
        end

        assign x_s = sync[1];

        // Debounce state and tick counter registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= S_LOW;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end

        // Next state: a pending level must survive STABLE_TICKS ticks; any
        // return of x_s (even alongside a tick) drops back and clears cnt.
        // NOTE: every output gets a default first so no path can infer a latch.
        always_comb begin
            state_nx = state;
            cnt_nx   = '0;
            unique case (state)
                S_LOW: begin
                    if (x_s) state_nx = S_RISE;
                end
                S_RISE: begin
                    if (!x_s) begin
                        state_nx = S_LOW;
                    end else if (bus.tick && cnt == LAST_CNT) begin
                        state_nx = S_HIGH;
                    end else if (bus.tick) begin
                        cnt_nx = cnt + CNT_W'(1);
                    end else begin
                        cnt_nx = cnt;
                    end
                end
                S_HIGH: begin
                    if (!x_s) state_nx = S_FALL;
                end
                S_FALL: begin
                    if (x_s) begin
                        state_nx = S_HIGH;
                    end else if (bus.tick && cnt == LAST_CNT) begin
                        state_nx = S_LOW;
                    end else if (bus.tick) begin
                        cnt_nx = cnt + CNT_W'(1);
                    end else begin
                        cnt_nx = cnt;
                    end
                end
                default: state_nx = S_LOW;
            endcase
        end

        assign level[ch] = state[1];

`ifdef PULSE_OUT_EN
        logic rise_q;

        // One-clk pulse aligned with the level going high; falls never pulse.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rise_q <= 1'b0;
            end else begin
                rise_q <= (state == S_RISE) && (state_nx == S_HIGH);
            end
        end

        assign rise[ch] = rise_q;
`else
        assign rise[ch] = 1'b0;
`endif
    end

    assign bus.left  = level[0];
    assign bus.right = level[1];

`ifdef PULSE_OUT_EN
    assign bus.left_rise  = rise[0];
    assign bus.right_rise = rise[1];
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus for the switch conditioner.
// Each raw change pushes the edge and level at which the output must move;
// every sampled output change pops and compares against that queue.
module tb_button_conditioner;

    localparam int STABLE_TICKS = 4;
    localparam int TICK_PERIOD  = 10;

    typedef struct {
        int   at_edge;
        logic value;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    button_conditioner_if bus ();

    button_conditioner #(
        .STABLE_TICKS(STABLE_TICKS),
        .CNT_W       (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    ev_t        exp_q[2][$];
    int         checks      = 0;
    int         errors      = 0;
    int         edge_n      = 0;
    bit         always_tick = 1'b0;
    logic [1:0] prev_level  = 2'b00;
    logic       cur_l       = 1'b1;
    logic       cur_r       = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, edge_n);
        end
    endtask

    function automatic bit tick_at(input int e);
        return always_tick || (e % TICK_PERIOD == 0);
    endfunction

    // Edge at which the k-th tick counts, for a raw change first applied at
    // change_edge: 2 synchroniser edges, 1 edge to enter the pending state,
    // and the tick on that entry edge is not counted.
    function automatic int tick_edge(input int change_edge, input int k);
        int e;
        int n;
        e = change_edge + 2;
        n = 0;
        while (n < k) begin
            e++;
            if (tick_at(e)) n++;
        end
        return e;
    endfunction

    task automatic push(input int ch, input logic v, input int at);
        ev_t ev;
        ev.at_edge = at;
        ev.value   = v;
        exp_q[ch].push_back(ev);
    endtask

    // Compare output changes against the scoreboard, and the rise pulses
    // against the expected rising events.
    task automatic monitor();
        for (int ch = 0; ch < 2; ch++) begin
            logic  lvl;
            logic  exp_rise;
            string nm;
            ev_t   ev;
            lvl      = ch ? bus.right : bus.left;
            nm       = ch ? "right" : "left";
            exp_rise = 1'b0;
            if (lvl !== prev_level[ch]) begin
                if (exp_q[ch].size() == 0) begin
                    check({nm, "_spurious"}, 32'(lvl), 32'(prev_level[ch]));
                end else begin
                    ev = exp_q[ch].pop_front();
                    check({nm, "_edge"}, edge_n, ev.at_edge);
                    check({nm, "_value"}, 32'(lvl), 32'(ev.value));
                    exp_rise = ev.value;
                end
                prev_level[ch] = lvl;
            end
`ifdef PULSE_OUT_EN
            check({nm, "_rise"}, 32'(ch ? bus.right_rise : bus.left_rise), 32'(exp_rise));
`endif
        end
    endtask

    task automatic cycle();
        bus.left_raw  = cur_l;
        bus.right_raw = cur_r;
        bus.tick      = tick_at(edge_n + 1);
        @(posedge clk);
        edge_n++;
        #1;
        monitor();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && k < budget) begin
            cycle();
            k++;
        end
        check("drain_left", exp_q[0].size(), 0);
        check("drain_right", exp_q[1].size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ce;
        int last;
        int target;
        logic v;

        bus.tick      = 1'b0;
        bus.left_raw  = 1'b1;
        bus.right_raw = 1'b1;

        // Reset held with both switches pressed: outputs stay low.
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i % 5 == 4) begin
                check("rst_left", 32'(bus.left), 0);
                check("rst_right", 32'(bus.right), 0);
            end
        end

        // Release: both channels rise together after sync + entry + 4 ticks.
        rst = 1'b1;
        ce  = edge_n + 1;
        push(0, 1'b1, tick_edge(ce, STABLE_TICKS));
        push(1, 1'b1, tick_edge(ce, STABLE_TICKS));
        wait_idle(100);

        // Simultaneous release: both fall together, no rise pulses.
        cur_l = 1'b0;
        cur_r = 1'b0;
        ce    = edge_n + 1;
        push(0, 1'b0, tick_edge(ce, STABLE_TICKS));
        push(1, 1'b0, tick_edge(ce, STABLE_TICKS));
        wait_idle(100);
        run(13);

        // Clean left press and release.
        cur_l = 1'b1;
        push(0, 1'b1, tick_edge(edge_n + 1, STABLE_TICKS));
        wait_idle(100);
        cur_l = 1'b0;
        push(0, 1'b0, tick_edge(edge_n + 1, STABLE_TICKS));
        wait_idle(100);
        run(7);

        // Bounce: toggle every 7 clk for 60 clk, ending high.
        last = 0;
        for (int i = 0; i < 60; i++) begin
            v = ((i / 7) % 2 == 0);
            if (v != cur_l) last = edge_n + 1;
            cur_l = v;
            cycle();
        end
        push(0, 1'b1, tick_edge(last, STABLE_TICKS));
        wait_idle(100);
        check("bounce_right", 32'(bus.right), 0);
        cur_l = 1'b0;
        push(0, 1'b0, tick_edge(edge_n + 1, STABLE_TICKS));
        wait_idle(100);

        // Glitch on right shorter than the debounce window.
        cur_r = 1'b1;
        run(25);
        cur_r = 1'b0;
        run(40);
        check("glitch_right", 32'(bus.right), 0);

        // Tick held high: debounce degenerates to counting clk cycles.
        always_tick = 1'b1;
        cur_r = 1'b1;
        ce    = edge_n + 1;
        push(1, 1'b1, ce + 2 + STABLE_TICKS);
        wait_idle(20);
        cur_r = 1'b0;
        ce    = edge_n + 1;
        push(1, 1'b0, ce + 2 + STABLE_TICKS);
        wait_idle(20);
        always_tick = 1'b0;
        run(5);

        // Mid-fall reset: press left, release, reset after 2 counted ticks.
        cur_l = 1'b1;
        push(0, 1'b1, tick_edge(edge_n + 1, STABLE_TICKS));
        wait_idle(100);
        cur_l  = 1'b0;
        target = tick_edge(edge_n + 1, 2);
        while (edge_n < target) cycle();
        check("fall_pending_left", 32'(bus.left), 1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_left", 32'(bus.left), 0);
        check("async_rst_right", 32'(bus.right), 0);
        prev_level = 2'b00;
        run(5);
        rst = 1'b1;
        run(60);
        check("post_rst_left", 32'(bus.left), 0);
        check("final_queue_left", exp_q[0].size(), 0);
        check("final_queue_right", exp_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage directly upstream of the thunderbird tail-light FSM.
- Takes the raw, asynchronous, bouncing left/right switch inputs and synchronises them to clk.
- Debounces each input against the clk_div enable tick and presents clean, stable levels to the FSM's left/right inputs.
- Instantiated in main between the board pins and the thunderbird, sharing clk, rst and clk_en.

Parameters:
- STABLE_TICKS, 4, number of consecutive sample ticks an input must hold a new value before the output changes; legal range 1..2**CNT_W-1.
- CNT_W, 3, width of each debounce counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (rst=0 resets).
- tick  input  1  sample enable from clk_div; one-clk pulse.
- left_raw  input  1  raw left switch, asynchronous to clk.
- right_raw  input  1  raw right switch, asynchronous to clk.
- left  output  1  debounced left level to the FSM.
- right  output  1  debounced right level to the FSM.
- left_rise  output  1  present only with PULSE_OUT_EN.
- right_rise  output  1  present only with PULSE_OUT_EN.

Behaviour:
- Reset: rst low asynchronously forces the following, held while rst=0:
  - synchroniser flops = 0
  - counters = 0
  - FSMs = S_LOW
  - left = right = 0
  - rise outputs = 0
- Reset release is synchronous in effect: the first active edge is the first clk edge with rst=1.
- Synchroniser: per channel, a 2-flop chain on clk gives x_s.
  - x_s lags the raw input by 2 clk edges.
  - No raw input drives any logic other than the first flop.
- Each channel is independent and identical, with a 4-state FSM and counter cnt[CNT_W-1:0]:
  - S_LOW: output 0, cnt=0. If x_s=1, go to S_RISE with cnt=0.
  - S_RISE: output 0.
    - If x_s=0: return to S_LOW, cnt=0. This is bounce rejection.
    - Else if tick and cnt==STABLE_TICKS-1: go to S_HIGH, cnt=0.
    - Else if tick: cnt=cnt+1.
  - S_HIGH: output 1, cnt=0. If x_s=0, go to S_FALL with cnt=0.
  - S_FALL: output 1. Mirror of S_RISE with levels swapped; completes to S_LOW.
- Output is registered and decoded from state only. It changes on the clk edge that processes the STABLE_TICKS-th tick after entering the pending state.
- Latency from a clean raw edge: 2 clk (sync) + 1 clk (enter pending) + time to STABLE_TICKS ticks.
- Boundary conditions:
  - tick coincident with the x_s return in a pending state: the return wins, cnt clears and the tick is not counted.
  - tick in the same cycle the FSM enters a pending state is not counted; counting starts on the next cycle.
  - cnt never exceeds STABLE_TICKS-1, so no wrap-around.
  - STABLE_TICKS=1: transition on the first tick in the pending state.
  - tick held constantly high: the block degenerates to counting clk cycles; this is legal.
  - left and right both stable high: both outputs are 1. Hazard interpretation belongs to the FSM, and no interlock is applied here.
  - rst asserted mid-pending: the state is abandoned immediately and the output is 0.

Optional Feature:
- Macro: PULSE_OUT_EN.
- Defined:
  - Adds left_rise and right_rise.
  - Each is a registered one-clk pulse, asserted on the clk edge where the channel moves S_RISE→S_HIGH, i.e. coincident with the output going 1.
  - No pulse on falling transitions or on reset release.
  - Reset value 0.
- Undefined: the rise ports and their logic are absent. Behaviour of left and right is identical in both builds.

Test Plan:
- Reset: hold rst=0 with left_raw=right_raw=1 for 20 clk → left=right=0, no rise pulse. Release → left goes 1 only after 2+1 clk plus 4 ticks.
- Clean press: STABLE_TICKS=4, tick every 10 clk, left_raw 0→1 → left=1 exactly at the clk edge of the 4th tick after entry into S_RISE. With PULSE_OUT_EN, left_rise=1 for that single cycle.
- Bounce: left_raw toggles every 7 clk for 60 clk, then settles at 1 → left stays 0 throughout the bouncing and rises 4 ticks after settling; right is unaffected.
- Glitch shorter than the debounce window: right_raw high for 25 clk (under 3 ticks) → right never asserts, cnt returns to 0.
- Simultaneous: both raw inputs 0→1 on the same cycle → left and right rise on the same clk edge. Release both → both fall together after 4 ticks, with no rise pulses on the fall.
- Mid-operation reset: assert rst during S_FALL after 2 ticks → output immediately 0. After release with the raw input still 0, output stays 0.
